alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
// Shares the single 8-bit ALU between N_REQ independent requesters (e.g. execute stage, LOOP counter unit).
// Each requester issues one op per handshake and gets a registered result + flags one cycle after grant.
// Round-robin arbitration; ALU is combinational and external, instantiated beside this block.
// Keeps a private 4-bit CCR per requester so flag-dependent ops (RLC/RRC/SETC/CLRC) never mix state across requesters.
// PARAMETERS
// DATA_W   8   operand/result width; must equal ALU width
// OP_W     4   ALU opcode width
// N_REQ    2   number of requesters, 2..4
// PORTS
// clk           in   1              clock, all state on rising edge
// rst           in   1              synchronous reset, active high
// req_valid     in   N_REQ          requester i has an op pending
// req_ready     out  N_REQ          op of requester i accepted this cycle (grant)
// req_a         in   N_REQ*DATA_W   operand A, slice i = [i*DATA_W +: DATA_W]
// req_b         in   N_REQ*DATA_W   operand B, same slicing
// req_op        in   N_REQ*OP_W     ALU opcode, same slicing
// resp_valid    out  N_REQ          result for requester i held in response register
// resp_ready    in   N_REQ          requester i consumes its response this cycle
// resp_out      out  N_REQ*DATA_W   registered ALU result
// resp_flags    out  N_REQ*4        registered flags {V,C,N,Z}, bit0=Z bit1=N bit2=C bit3=V
// ccr_wr_en     in   N_REQ          overwrite CCR of requester i (flag restore)
// ccr_wr_data   in   N_REQ*4        CCR value to write, same bit order
// ccr_q         out  N_REQ*4        current CCR of each requester
// alu_a/alu_b   out  DATA_W         operands to ALU; 0 when no grant
// alu_opcode    out  OP_W           opcode to ALU; 0 when no grant
// alu_ccr       out  4              granted requester's CCR to ALU; 0 when no grant
// alu_out       in   DATA_W         ALU result
// alu_z/n/c/v   in   1              ALU new flags
// BEHAVIOUR
// - Reset: req_ready=0, resp_valid=0, resp_out=0, resp_flags=0, every CCR=0, rr pointer=0, ALU drive=0.
// - Eligible(i) = req_valid[i] & !ccr_wr_en[i] & (!resp_valid[i] | resp_ready[i]).
// - At most one grant per cycle: first eligible index scanning from rr_ptr upward, wrapping at N_REQ.
// - Grant i in cycle T: req_ready[i]=1 (combinational, same cycle); ALU driven with slice i and CCR[i].
// - Edge ending T: resp_out[i]<=alu_out, resp_flags[i]<={v,c,n,z}, resp_valid[i]<=1, CCR[i]<={v,c,n,z}.
//   Latency exactly 1: resp_valid[i] high in T+1.
// - rr_ptr<=(granted+1) mod N_REQ after a grant; unchanged with no grant.
// - resp_valid[i] clears on resp_ready[i] unless a new grant to i in the same cycle refills it.
//   Consume+refill gives back-to-back throughput of 1 op/cycle per requester.
// - resp_ready[i] with resp_valid[i]=0 is ignored.
// - Response registers hold value while resp_valid=1 & resp_ready=0; requester i is then not granted.
// - ccr_wr_en[i]: CCR[i]<=ccr_wr_data[i] at edge. Requester i is not eligible that cycle, so there is no write/update race.
//   Other requesters arbitrate normally.
// - Flags reaching ALU are the granted requester's own CCR.
//   SETC/CLRC (op 7/8) return out=0 and update only that CCR.
// - Unused req slices (req_valid=0) are don't-care; no X may propagate to alu_* when no grant.
// - rst mid-operation: pending responses discarded, CCRs cleared, req_valid ignored during reset cycle.
// - req_ready never asserts without req_valid; requester must hold req_* stable until req_ready.
// TESTING
// - Reset: assert rst with all req_valid=1 -> req_ready=0, resp_valid=0, ccr_q=0; first grant to req0 after release.
// - Single op: req0 ADD A=0x7F B=0x01 -> T+1 resp_out[0]=0x80, flags V=1 N=1 C=0 Z=0, ccr_q[0]=4'b1010.
// - Round robin: both valid every cycle, resp_ready=1 -> grants alternate 0,1,0,1; each resp 1 cycle after its grant.
// - CCR isolation: req0 SETC, then req1 RLC B=0x01 with CCR1=0 -> resp_out[1]=0x02; req0 RLC B=0x01 -> 0x03.
// - Backpressure: req1 resp_ready=0 with result held -> req1 never granted, resp_out[1] stable; req0 gets every cycle.
// - CCR write collision: ccr_wr_en[0]=1 data=4'b0100 while req0 valid -> no grant to 0 that cycle, ccr_q[0]=0100, grant next cycle.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between N_REQ requesters.
// Each requester owns a private CCR and a one-entry registered response slot.
module alu_share_arbiter #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4,
    parameter int N_REQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*OP_W-1:0] req_op,
    output logic [N_REQ-1:0]      resp_valid,
    input  logic [N_REQ-1:0]      resp_ready,
    output logic [N_REQ*DATA_W-1:0] resp_out,
    output logic [N_REQ*4-1:0]    resp_flags,
    input  logic [N_REQ-1:0]      ccr_wr_en,
    input  logic [N_REQ*4-1:0]    ccr_wr_data,
    output logic [N_REQ*4-1:0]    ccr_q,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [OP_W-1:0]       alu_opcode,
    output logic [3:0]            alu_ccr,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic                  alu_z,
    input  logic                  alu_n,
    input  logic                  alu_c,
    input  logic                  alu_v
);

    localparam int PTR_W = (N_REQ > 2) ? 2 : 1;
    localparam logic [PTR_W:0]   N_REQ_W  = (PTR_W + 1)'(N_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

    logic [N_REQ-1:0]        resp_valid_q, resp_valid_d;
    logic [N_REQ*DATA_W-1:0] resp_out_q, resp_out_d;
    logic [N_REQ*4-1:0]      resp_flags_q, resp_flags_d;
    logic [N_REQ*4-1:0]      ccr_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;

    logic [N_REQ-1:0] eligible_s;
    logic [PTR_W:0]   scan_idx_s;
    logic             grant_valid_s;
    logic [PTR_W-1:0] grant_idx_s;
    logic [3:0]       alu_flags_s;

    assign resp_valid  = resp_valid_q;
    assign resp_out    = resp_out_q;
    assign resp_flags  = resp_flags_q;
    assign alu_flags_s = {alu_v, alu_c, alu_n, alu_z};

    // Eligibility and round-robin scan starting at rr_ptr_q, wrapping at N_REQ.
    always_comb begin
        // A CCR write blocks its own requester so the write never races a flag update.
        eligible_s    = req_valid & ~ccr_wr_en & (~resp_valid_q | resp_ready) & {N_REQ{~rst}};
        grant_valid_s = 1'b0;
        grant_idx_s   = PTR_ZERO;
        scan_idx_s    = {(PTR_W + 1){1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx_s = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
            if (scan_idx_s >= N_REQ_W) begin
                scan_idx_s = scan_idx_s - N_REQ_W;
            end else begin
                scan_idx_s = scan_idx_s;
            end
            if (!grant_valid_s && eligible_s[scan_idx_s[PTR_W-1:0]]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = scan_idx_s[PTR_W-1:0];
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Grant handshake and ALU operand mux; everything forced to zero without a grant.
    always_comb begin
        req_ready  = {N_REQ{1'b0}};
        alu_a      = {DATA_W{1'b0}};
        alu_b      = {DATA_W{1'b0}};
        alu_opcode = {OP_W{1'b0}};
        alu_ccr    = 4'b0000;
        if (grant_valid_s) begin
            req_ready[grant_idx_s] = 1'b1;
            alu_a      = req_a[int'(grant_idx_s)*DATA_W +: DATA_W];
            alu_b      = req_b[int'(grant_idx_s)*DATA_W +: DATA_W];
            alu_opcode = req_op[int'(grant_idx_s)*OP_W +: OP_W];
            alu_ccr    = ccr_q[int'(grant_idx_s)*4 +: 4];
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
    end

    // Next state: consume frees a slot, a grant (re)fills it, CCR writes and updates.
    always_comb begin
        resp_valid_d = resp_valid_q & ~resp_ready;
        resp_out_d   = resp_out_q;
        resp_flags_d = resp_flags_q;
        ccr_d        = ccr_q;
        rr_ptr_d     = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (ccr_wr_en[i]) begin
                ccr_d[i*4 +: 4] = ccr_wr_data[i*4 +: 4];
            end else begin
                ccr_d[i*4 +: 4] = ccr_q[i*4 +: 4];
            end
        end
        if (grant_valid_s) begin
            resp_valid_d[grant_idx_s]                    = 1'b1;
            resp_out_d[int'(grant_idx_s)*DATA_W +: DATA_W] = alu_out;
            resp_flags_d[int'(grant_idx_s)*4 +: 4]       = alu_flags_s;
            ccr_d[int'(grant_idx_s)*4 +: 4]              = alu_flags_s;
            if (grant_idx_s == LAST_IDX) begin
                rr_ptr_d = PTR_ZERO;
            end else begin
                rr_ptr_d = grant_idx_s + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= {N_REQ{1'b0}};
            resp_out_q   <= {(N_REQ*DATA_W){1'b0}};
            resp_flags_q <= {(N_REQ*4){1'b0}};
            ccr_q        <= {(N_REQ*4){1'b0}};
            rr_ptr_q     <= PTR_ZERO;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_out_q   <= resp_out_d;
            resp_flags_q <= resp_flags_d;
            ccr_q        <= ccr_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: bench-side ALU, per-requester expectation queues,
// and a negedge monitor holding an abstract model of grants, held responses and CCRs.
module tb_alu_share_arbiter;

    localparam logic [3:0] OP_ADD = 4'd0, OP_XOR = 4'd4, OP_RLC = 4'd5, OP_SETC = 4'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready, ccr_wr_en;
    logic [15:0] req_a, req_b, resp_out;
    logic [7:0]  req_op, resp_flags, ccr_wr_data, ccr_q;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [3:0]  alu_opcode, alu_ccr;
    logic        alu_z, alu_n, alu_c, alu_v;

    int n_tests = 0;
    int n_fail  = 0;
    logic        mon_en = 1'b0;
    logic [11:0] exp_q [2][$];
    logic [3:0]  ccr_m [2];
    logic [1:0]  m_rv;
    int          m_ptr;
    logic [3:0]  m_ccr [2];
    logic [1:0]  mon_elig, mon_rdy;
    int          mon_g;
    logic [11:0] mon_e;

    alu_share_arbiter #(.DATA_W(8), .OP_W(4), .N_REQ(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_out(resp_out), .resp_flags(resp_flags),
        .ccr_wr_en(ccr_wr_en), .ccr_wr_data(ccr_wr_data), .ccr_q(ccr_q),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_ccr(alu_ccr),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v)
    );

    always #5 clk = ~clk;

    // ALU behaviour: returns {V,C,N,Z, result}.
    function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [3:0] ccr);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        logic [3:0] f;
        s = 9'd0; r = 8'd0; c = ccr[2]; v = ccr[3];
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                        v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
                        v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd2: begin r = a & b; v = 1'b0; end
            4'd3: begin r = a | b; v = 1'b0; end
            4'd4: begin r = a ^ b; v = 1'b0; end
            4'd5: begin r = {b[6:0], ccr[2]}; c = b[7]; end
            4'd6: begin r = {ccr[2], b[7:1]}; c = b[0]; end
            default: r = 8'd0;
        endcase
        f = {v, c, r[7], (r == 8'd0)};
        if (op == 4'd7)      f = ccr | 4'b0100;
        else if (op == 4'd8) f = ccr & 4'b1011;
        else if (op > 4'd8)  f = ccr;
        return {f, r};
    endfunction

    always_comb {alu_v, alu_c, alu_n, alu_z, alu_out} = alu_f(alu_opcode, alu_a, alu_b, alu_ccr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t: bound expired or expectation missing", name, $time);
    endtask

    // Issue an op; the expected response is computed now from the requester's own CCR.
    task automatic issue(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [11:0] r;
        r = alu_f(op, a, b, ccr_m[i]);
        ccr_m[i] = r[11:8];
        req_valid[i] = 1'b1;
        req_op[i*4 +: 4] = op;
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        exp_q[i].push_back(r);
    endtask

    task automatic wr_ccr(input int i, input logic [3:0] d);
        ccr_wr_en[i] = 1'b1;
        ccr_wr_data[i*4 +: 4] = d;
        ccr_m[i] = d;
    endtask

    task automatic step();
        logic [1:0] got;
        #2;
        got = req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~got;
        ccr_wr_en = 2'b00;
    endtask

    task automatic wait_grant(input int i);
        int n;
        n = 0;
        while (req_valid[i] && n < 20) begin
            step();
            n++;
        end
        if (req_valid[i]) fail_now("grant_timeout");
    endtask

    // Monitor: predicted grant, held responses, CCRs and ALU drive, then advance the model.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++)
                mon_elig[i] = req_valid[i] & ~ccr_wr_en[i] & (~m_rv[i] | resp_ready[i]) & ~rst;
            mon_g = -1;
            for (int k = 0; k < 2; k++)
                if (mon_g < 0 && mon_elig[(m_ptr + k) % 2]) mon_g = (m_ptr + k) % 2;
            mon_rdy = (mon_g < 0) ? 2'b00 : (2'b01 << mon_g);
            check("req_ready", {30'd0, req_ready}, {30'd0, mon_rdy});
            check("resp_valid", {30'd0, resp_valid}, {30'd0, m_rv});
            for (int i = 0; i < 2; i++) check("ccr_q", {28'd0, ccr_q[i*4 +: 4]}, {28'd0, m_ccr[i]});
            if (mon_g < 0) begin
                check("alu_idle", {8'd0, alu_a, alu_b, alu_opcode, alu_ccr}, 32'd0);
            end else begin
                check("alu_a", {24'd0, alu_a}, {24'd0, req_a[mon_g*8 +: 8]});
                check("alu_b", {24'd0, alu_b}, {24'd0, req_b[mon_g*8 +: 8]});
                check("alu_op", {28'd0, alu_opcode}, {28'd0, req_op[mon_g*4 +: 4]});
                check("alu_ccr", {28'd0, alu_ccr}, {28'd0, m_ccr[mon_g]});
            end
            for (int i = 0; i < 2; i++) begin
                if (!rst && m_rv[i]) begin
                    if (exp_q[i].size() == 0) begin
                        fail_now("resp_no_expect");
                    end else begin
                        mon_e = exp_q[i][0];
                        check("resp_out", {24'd0, resp_out[i*8 +: 8]}, {24'd0, mon_e[7:0]});
                        check("resp_flags", {28'd0, resp_flags[i*4 +: 4]}, {28'd0, mon_e[11:8]});
                    end
                end
            end
            if (rst) begin
                m_rv = 2'b00; m_ptr = 0; m_ccr[0] = 4'd0; m_ccr[1] = 4'd0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (ccr_wr_en[i]) m_ccr[i] = ccr_wr_data[i*4 +: 4];
                    if (m_rv[i] && resp_ready[i]) begin
                        if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
                        m_rv[i] = 1'b0;
                    end
                end
                if (mon_g >= 0) begin
                    if (exp_q[mon_g].size() == 0) begin
                        fail_now("grant_no_expect");
                    end else begin
                        mon_e = exp_q[mon_g][$];
                        m_ccr[mon_g] = mon_e[11:8];
                    end
                    m_rv[mon_g] = 1'b1;
                    m_ptr = (mon_g + 1) % 2;
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; resp_ready = 2'b11; ccr_wr_en = 2'b00;
        req_a = 16'd0; req_b = 16'd0; req_op = 8'd0; ccr_wr_data = 8'd0;
        ccr_m[0] = 4'd0; ccr_m[1] = 4'd0;
        m_rv = 2'b00; m_ptr = 0; m_ccr[0] = 4'd0; m_ccr[1] = 4'd0;
        step(); mon_en = 1'b1; step();

        // Both valid during reset: ignored; first grant to req0 after release.
        issue(0, OP_ADD, 8'h7F, 8'h01);
        issue(1, OP_ADD, 8'h10, 8'h20);
        step();
        rst = 1'b0;
        step();
        #1;
        check("single_out", {24'd0, resp_out[7:0]}, 32'h80);
        check("single_flags", {28'd0, resp_flags[3:0]}, 32'b1010);
        check("single_ccr", {28'd0, ccr_q[3:0]}, 32'b1010);
        step();

        // Round robin with both requesters always valid.
        repeat (8) begin
            for (int i = 0; i < 2; i++)
                if (!req_valid[i]) issue(i, OP_ADD, 8'($urandom), 8'($urandom));
            step();
        end
        wait_grant(0); wait_grant(1); step(); step();

        // CCR isolation between requesters.
        wr_ccr(1, 4'b0000);
        issue(0, OP_SETC, 8'h00, 8'h00);
        wait_grant(0);
        issue(1, OP_RLC, 8'h00, 8'h01);
        wait_grant(1);
        #1 check("iso_req1", {24'd0, resp_out[15:8]}, 32'h02);
        issue(0, OP_RLC, 8'h00, 8'h01);
        wait_grant(0);
        #1 check("iso_req0", {24'd0, resp_out[7:0]}, 32'h03);
        step();

        // Backpressure on req1: result held, req1 starved, req0 served every cycle.
        resp_ready = 2'b01;
        issue(1, OP_ADD, 8'h05, 8'h03);
        wait_grant(1);
        issue(1, OP_ADD, 8'h01, 8'h01);
        repeat (6) begin
            if (!req_valid[0]) issue(0, OP_XOR, 8'($urandom), 8'($urandom));
            #1;
            check("bp_hold", {24'd0, resp_out[15:8]}, 32'h08);
            check("bp_blocked", {31'd0, req_ready[1]}, 32'd0);
            step();
        end
        resp_ready = 2'b11;
        wait_grant(1); wait_grant(0); step(); step();

        // CCR write colliding with a pending op of the same requester.
        wr_ccr(0, 4'b0100);
        issue(0, OP_RLC, 8'h00, 8'h01);
        #1 check("coll_no_grant", {31'd0, req_ready[0]}, 32'd0);
        step();
        #1;
        check("coll_ccr", {28'd0, ccr_q[3:0]}, 32'b0100);
        check("coll_grant", {31'd0, req_ready[0]}, 32'd1);
        step();
        #1 check("coll_result", {24'd0, resp_out[7:0]}, 32'h03);
        step();

        // Reset in the middle of operation with a held response.
        resp_ready = 2'b00;
        issue(0, OP_ADD, 8'h33, 8'h44);
        wait_grant(0);
        rst = 1'b1; req_valid = 2'b00;
        exp_q[0].delete(); exp_q[1].delete();
        ccr_m[0] = 4'd0; ccr_m[1] = 4'd0;
        issue(1, OP_ADD, 8'hFF, 8'h01);
        step();
        #1;
        check("rst_ccr", {24'd0, ccr_q}, 32'd0);
        check("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
        rst = 1'b0; resp_ready = 2'b11;
        wait_grant(1); step();

        // Randomized traffic with random backpressure and CCR restores.
        repeat (400) begin
            resp_ready = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i]) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4: issue(i, 4'($urandom_range(0, 8)), 8'($urandom), 8'($urandom));
                        5: begin
                            wr_ccr(i, 4'($urandom));
                            issue(i, 4'($urandom_range(0, 8)), 8'($urandom), 8'($urandom));
                        end
                        6: wr_ccr(i, 4'($urandom));
                        default: ;
                    endcase
                end
            end
            step();
        end
        resp_ready = 2'b11;
        wait_grant(0); wait_grant(1);
        repeat (3) step();
        check("drain_q0", exp_q[0].size(), 32'd0);
        check("drain_q1", exp_q[1].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
